dig_out_rails_ctrl: RTL
=======================

Name: dig_out_rails_ctrl

Overview:
Bus-side register and sequencing stage that sits directly upstream of four per-bank digital-output rail switch sequencers (one per bank of 4 outputs). It accepts host writes of rail codes, holds each bank's applied code stable for the downstream sequencer, and issues the rail_change_start / rail_change_ack handshake. It queues writes that arrive mid-change, detects a missing ack with a timeout, and provides status readback.

Parameters:
RAILS_DELAY_TIME_EXP, 16, exponent used by the downstream sequencer; settle wait = 2^EXP + 4 xclk cycles
ACK_TIMEOUT, 15, max xclk cycles rail_change_start may stay high without ack (range 1..255)

Ports:
xclk  in  1  system clock, 37.5 MHz
reset  in  1  synchronous, active-high reset
wr_strobe  in  1  one-cycle write pulse
rd_strobe  in  1  one-cycle read pulse
addr  in  3  register address
wr_data  in  16  write data
rd_data  out  16  registered read data
rail_change_start  out  4  per-bank start strobe to sequencer
rail_change_ack  in  4  per-bank ack from sequencer
stored_bank_rails  out  16  applied codes; bank n at [4n+3:4n] ([1:0] top, [3:2] bottom)
busy  out  4  per-bank change in progress

Behaviour:
- Reset: stored_bank_rails = 16'hFFFF (all rails NONE); rail_change_start = 0; busy = 0; rd_data = 0; pending flags, error flags, and counters = 0. Reset mid-change aborts it immediately.
- Address map:
  - 0-3: bank config. Write: wr_data[3:0] is the requested code. Read: {7'b0, pending, pending_code[3:0], applied[3:0]}.
  - 4: status. Read: {8'b0, timeout_err[3:0], busy[3:0]}. Write: 1 in wr_data[7:4] clears the matching timeout_err bit.
  - 5: all-off. Any write requests code 4'hF on all four banks.
  - 6-7: reads return 0; writes are ignored.
- rd_data updates on the cycle after rd_strobe and holds until the next read.
- Per-bank FSM, states IDLE, START, SETTLE:
  - IDLE + request (write or all-off): applied <= code; rail_change_start[n] <= 1; busy[n] <= 1; ack timer cleared; go to START. A change is launched even if the code equals the current applied code.
  - START: start stays high until rail_change_ack[n] is sampled high. Start drops on the next cycle, the settle counter is cleared, and the FSM goes to SETTLE.
  - START, timeout: if ack is not seen after ACK_TIMEOUT cycles, drop start, set timeout_err[n] (sticky), busy[n] <= 0, return to IDLE. applied stays at the new code.
  - SETTLE: count to 2^EXP + 4 cycles, then go to IDLE. If pending is set, launch the pending code on the same cycle as that IDLE entry (busy stays 1); otherwise busy[n] <= 0.
- Hold rule: applied[n] must not change in START or SETTLE, because the downstream sequencer samples it at the end of its delay. Requests in these states go to pending_code[n] with pending <= 1; the last write wins.
- Simultaneous events:
  - Bank write and all-off in the same cycle cannot happen (single address); back-to-back writes are handled in order.
  - A write landing on the same cycle as the SETTLE->IDLE transition is treated as pending and launches one cycle later; no request is lost.
  - Ack already high on START entry is accepted on the first START cycle.
- The settle counter is sized EXP+2 bits; no wrap-around occurs before terminal count.
- The four banks operate fully independently; all-off queues on busy banks and launches immediately on idle ones.

Test Plan:
- EXP=4 (settle 20 cycles). Reset, then write addr1=4'h6 -> start[1] high next cycle, stored[7:4]=4'h6, busy=4'b0010. Ack after 3 cycles -> start drops, busy clears 20 cycles later.
- During bank 1 SETTLE, write 4'h2 then 4'h5 -> stored[7:4] stays 6. Read addr1 -> 16'h0156. After settle -> relaunch with stored[7:4]=5, pending=0.
- Never ack bank 2 after a write (ACK_TIMEOUT=15) -> start[2] falls after 15 cycles, status read = 16'h0040. Write addr4 with wr_data=16'h0040 -> status = 16'h0000.
- Bank 0 busy, then write addr5 -> banks 1-3 start immediately with code F. Bank 0 goes to F after its settle; final stored = 16'hFFFF.
- Assert reset while bank 3 is in SETTLE with pending set -> next cycle all outputs are at reset values and pending is cleared.
- Write addr 6, read addr 7 -> no start or state change; rd_data = 0.

Source files
------------

// File: rtl/dig_out_rails_ctrl.sv
// rtl/dig_out_rails_ctrl.sv - rail code register bank with per-bank start/ack sequencing
module dig_out_rails_ctrl #(
   parameter int RAILS_DELAY_TIME_EXP = 16,
   parameter int ACK_TIMEOUT          = 15
) (
   input  logic        xclk,
   input  logic        reset,
   input  logic        wr_strobe,
   input  logic        rd_strobe,
   input  logic [2:0]  addr,
   input  logic [15:0] wr_data,
   output logic [15:0] rd_data,
   output logic [3:0]  rail_change_start,
   input  logic [3:0]  rail_change_ack,
   output logic [15:0] stored_bank_rails,
   output logic [3:0]  busy
);
   localparam int CW = RAILS_DELAY_TIME_EXP + 2;
   localparam logic [CW-1:0] SETTLE_LAST = CW'((1 << RAILS_DELAY_TIME_EXP) + 3);
   localparam logic [7:0]    ACK_LAST    = 8'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, START, SETTLE} bank_state_t;

   bank_state_t   state [4];
   bank_state_t   state_n [4];
   logic [3:0]    applied [4];
   logic [3:0]    applied_n [4];
   logic [3:0]    pend_code [4];
   logic [3:0]    pend_code_n [4];
   logic [7:0]    ack_tmr [4];
   logic [7:0]    ack_tmr_n [4];
   logic [CW-1:0] settle_cnt [4];
   logic [CW-1:0] settle_cnt_n [4];
   logic [3:0]    pend, pend_n;
   logic [3:0]    start_n, busy_n;
   logic [3:0]    terr, terr_n;
   logic [3:0]    req;
   logic [3:0]    req_code;
   logic          status_wr;
   logic          unused_wr_bits;

   assign unused_wr_bits = ^wr_data[15:8];
   assign status_wr = wr_strobe && (addr == 3'd4);

   always_comb begin
      req      = 4'b0;
      req_code = wr_data[3:0];
      if (wr_strobe) begin
         if (!addr[2]) begin
            req[addr[1:0]] = 1'b1;
         end else if (addr == 3'd5) begin
            req      = 4'hF;
            req_code = 4'hF;
         end
      end
   end

   always_comb begin
      state_n      = state;
      applied_n    = applied;
      pend_code_n  = pend_code;
      ack_tmr_n    = ack_tmr;
      settle_cnt_n = settle_cnt;
      pend_n       = pend;
      start_n      = rail_change_start;
      busy_n       = busy;
      terr_n       = terr;
      for (int b = 0; b < 4; b++) begin
         if (status_wr && wr_data[4+b]) terr_n[b] = 1'b0;
         case (state[b])
            IDLE: begin
               // a fresh request overrides anything left queued
               if (req[b] || pend[b]) begin
                  applied_n[b] = req[b] ? req_code : pend_code[b];
                  pend_n[b]    = 1'b0;
                  start_n[b]   = 1'b1;
                  busy_n[b]    = 1'b1;
                  ack_tmr_n[b] = 8'd0;
                  state_n[b]   = START;
               end
            end
            START: begin
               if (req[b]) begin
                  pend_n[b]      = 1'b1;
                  pend_code_n[b] = req_code;
               end
               if (rail_change_ack[b]) begin
                  start_n[b]      = 1'b0;
                  settle_cnt_n[b] = '0;
                  state_n[b]      = SETTLE;
               end else if (ack_tmr[b] == ACK_LAST) begin
                  start_n[b] = 1'b0;
                  terr_n[b]  = 1'b1;
                  busy_n[b]  = 1'b0;
                  state_n[b] = IDLE;
               end else begin
                  ack_tmr_n[b] = ack_tmr[b] + 8'd1;
               end
            end
            SETTLE: begin
               if (req[b]) begin
                  pend_n[b]      = 1'b1;
                  pend_code_n[b] = req_code;
               end
               if (settle_cnt[b] == SETTLE_LAST) begin
                  state_n[b] = IDLE;
                  // a write on this very cycle stays queued and launches from IDLE
                  if (!req[b] && pend[b]) begin
                     applied_n[b] = pend_code[b];
                     pend_n[b]    = 1'b0;
                     start_n[b]   = 1'b1;
                     ack_tmr_n[b] = 8'd0;
                     state_n[b]   = START;
                  end else if (!req[b]) begin
                     busy_n[b] = 1'b0;
                  end
               end else begin
                  settle_cnt_n[b] = settle_cnt[b] + 1'b1;
               end
            end
            default: state_n[b] = IDLE;
         endcase
      end
   end

   always_ff @(posedge xclk) begin
      if (reset) begin
         for (int b = 0; b < 4; b++) begin
            state[b]      <= IDLE;
            applied[b]    <= 4'hF;
            pend_code[b]  <= 4'h0;
            ack_tmr[b]    <= 8'd0;
            settle_cnt[b] <= '0;
         end
         pend              <= 4'b0;
         terr              <= 4'b0;
         rail_change_start <= 4'b0;
         busy              <= 4'b0;
      end else begin
         state             <= state_n;
         applied           <= applied_n;
         pend_code         <= pend_code_n;
         ack_tmr           <= ack_tmr_n;
         settle_cnt        <= settle_cnt_n;
         pend              <= pend_n;
         terr              <= terr_n;
         rail_change_start <= start_n;
         busy              <= busy_n;
      end
   end

   always_ff @(posedge xclk) begin
      if (reset) begin
         rd_data <= 16'h0000;
      end else if (rd_strobe) begin
         case (addr)
            3'd0, 3'd1, 3'd2, 3'd3:
               rd_data <= {7'b0, pend[addr[1:0]], pend_code[addr[1:0]], applied[addr[1:0]]};
            3'd4:    rd_data <= {8'b0, terr, busy};
            default: rd_data <= 16'h0000;
         endcase
      end
   end

   assign stored_bank_rails = {applied[3], applied[2], applied[1], applied[0]};
endmodule
